data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Multi-cycle data-memory responder that serves load/store requests issued by the pipeline's memory-access stage. It accepts one request per valid/ready handshake and decodes RISC-V funct3 into byte, half-word or word accesses. It performs the access against an internal word array after a configurable number of wait states, then returns a one-cycle response carrying sign- or zero-extended load data or an access-fault flag. It replaces the single-cycle RAM model so the pipeline can be exercised against realistic memory latency.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in storage; power of two, at least 2.
WAIT_CYCLES, 2, wait states between accept and response; 0 to 15.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
reqValid  input  1  request present
reqReady  output  1  responder can accept a request this cycle
address  input  32  byte address
writeData  input  32  store data, right-aligned
funct3  input  3  instruction[14:12], access size and sign
memRead  input  1  request is a load
memWrite  input  1  request is a store
respValid  output  1  one-cycle pulse: response valid
readData  output  32  load result, valid with respValid and held until the next response
accessFault  output  1  misaligned or illegal access, valid with respValid

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - respValid=0, readData=0, accessFault=0, reqReady=1 after release.
  - Storage contents are not reset.
  - Reset during WAIT or RESP aborts the request. A store whose commit edge has not occurred is not written.
- States: IDLE, WAIT, RESP.
  - IDLE: reqReady=1. Accept on reqValid && reqReady.
    - Latch address, writeData, funct3, memRead, memWrite.
    - Load the wait counter with WAIT_CYCLES.
    - Go to WAIT, or directly to RESP if WAIT_CYCLES=0.
  - WAIT: reqReady=0; the request inputs are ignored. Decrement the counter each cycle. When the counter reaches 1, the next edge goes to RESP.
  - RESP: respValid=1 for exactly one cycle, reqReady=0. Next state is IDLE.
- Latency: accept at edge N gives respValid high in cycle N+WAIT_CYCLES+1. Back-to-back requests are separated by at least WAIT_CYCLES+2 cycles.
- Commit point:
  - A store writes storage on the edge entering RESP.
  - Load data and accessFault are registered on the same edge.
- Word index is address[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo the storage size.
- Little-endian byte lanes. Byte lane = address[1:0]; half-word lane = address[1].
- Loads:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half-word.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half-word.
- Stores:
  - 000 SB and 001 SH write only the addressed lanes, using the low bits of writeData.
  - 010 SW writes all four lanes.
- Faults: accessFault=1, readData=0, no storage change, for any of:
  - half-word access with address[0]=1;
  - word access with address[1:0]!=0;
  - load with funct3 in {011,110,111};
  - store with funct3 other than 000/001/010.
- memRead and memWrite both 1: treated as a store. Load data is returned as 0.
- Neither memRead nor memWrite: the request still completes. Response is readData=0, accessFault=0, no storage change.
- accessFault is cleared with every non-faulting response.
- reqValid held high through RESP is not accepted until the cycle after RESP (IDLE).

Test Plan:
- WAIT_CYCLES=2. Accept SW addr 0x100 data 0xDEADBEEF at edge 0 -> respValid only in cycle 3, accessFault=0. Then LW 0x100 -> readData 0xDEADBEEF.
- After the above: LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD; LHU 0x100 -> 0x0000BEEF.
- SB 0x101 data 0x12345655, then LW 0x100 -> 0xDEAD55EF. SH 0x102 data 0x0000CAFE, then LW 0x100 -> 0xCAFE55EF.
- LH 0x101 -> accessFault=1, readData=0. SW 0x102 data 0 -> accessFault=1; LW 0x100 still 0xCAFE55EF. Load funct3=011 -> accessFault=1.
- Hold reqValid high continuously with a second request changing during WAIT -> reqReady=0 in WAIT/RESP. Only the first request is served; the second is accepted in the first IDLE cycle after RESP.
- Assert rst_n=0 in the WAIT of SW 0x200 data 0xA5A5A5A5, then LW 0x200 -> old contents. Outputs read 0 immediately on reset assertion.
- Build with WAIT_CYCLES=0 -> respValid in the cycle after accept. Address 0x100+4*DEPTH_WORDS aliases 0x100.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle load/store data memory responder with wait states
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic [2:0]  funct3,
    input  logic        memRead,
    input  logic        memWrite,
    output logic        respValid,
    output logic [31:0] readData,
    output logic        accessFault
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        access_fault_q, access_fault_d;
    logic [31:0] read_data_q, read_data_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] op_addr, op_wdata;
    logic [2:0]  op_f3;
    logic        op_rd, op_wr;
    logic [AW-1:0] idx;
    logic        is_store, is_load, misaligned, fault, commit, mem_we;
    logic [31:0] word, load_val, store_lanes;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [3:0]  byte_en;
    logic        unused_addr_hi;

    // In IDLE the live request is used so a zero-wait build can commit on the accept edge.
    always_comb begin
        op_addr  = (state_q == S_IDLE) ? address   : addr_q;
        op_wdata = (state_q == S_IDLE) ? writeData : wdata_q;
        op_f3    = (state_q == S_IDLE) ? funct3    : f3_q;
        op_rd    = (state_q == S_IDLE) ? memRead   : rd_q;
        op_wr    = (state_q == S_IDLE) ? memWrite  : wr_q;
    end

    assign idx            = op_addr[AW+1:2];
    assign unused_addr_hi = ^op_addr[31:AW+2];
    assign is_store       = op_wr;
    assign is_load        = op_rd & ~op_wr;

    always_comb begin
        misaligned = ((op_f3[1:0] == 2'b01) & op_addr[0])
                   | ((op_f3[1:0] == 2'b10) & (op_addr[1:0] != 2'b00));
        fault      = (is_store & (op_f3[2] | (op_f3[1:0] == 2'b11) | misaligned))
                   | (is_load  & ((op_f3 == 3'b011) | (op_f3[2:1] == 2'b11) | misaligned));
    end

    always_comb begin
        word      = mem[idx];
        lane_byte = word[{op_addr[1:0], 3'b000} +: 8];
        lane_half = word[{op_addr[1], 4'b0000} +: 16];
        case (op_f3)
            3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'b0, lane_byte};
            3'b101:  load_val = {16'b0, lane_half};
            default: load_val = '0;
        endcase
        if (!is_load || fault) begin
            load_val = '0;
        end
    end

    always_comb begin
        case (op_f3[1:0])
            2'b00:   byte_en = 4'b0001 << op_addr[1:0];
            2'b01:   byte_en = op_addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        case (op_f3[1:0])
            2'b00:   store_lanes = {4{op_wdata[7:0]}};
            2'b01:   store_lanes = {2{op_wdata[15:0]}};
            default: store_lanes = op_wdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        f3_d           = f3_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        read_data_d    = read_data_q;
        access_fault_d = access_fault_q;
        case (state_q)
            S_IDLE: begin
                if (reqValid) begin
                    addr_d  = address;
                    wdata_d = writeData;
                    f3_d    = funct3;
                    rd_d    = memRead;
                    wr_d    = memWrite;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        commit = (state_d == S_RESP) && (state_q != S_RESP);
        if (commit) begin
            read_data_d    = load_val;
            access_fault_d = fault;
        end
        resp_valid_d = (state_d == S_RESP);
        req_ready_d  = (state_d == S_IDLE);
    end

    // A reset in flight must never let a pending store reach storage.
    assign mem_we = commit & is_store & ~fault & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            f3_q           <= '0;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            access_fault_q <= 1'b0;
            read_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            f3_q           <= f3_d;
            rd_q           <= rd_d;
            wr_q           <= wr_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            access_fault_q <= access_fault_d;
            read_data_q    <= read_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= store_lanes[8*b +: 8];
                end
            end
        end
    end

    assign reqReady    = req_ready_q;
    assign respValid   = resp_valid_q;
    assign readData    = read_data_q;
    assign accessFault = access_fault_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;
    localparam int D0 = 1024;
    localparam int D1 = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0, writeData = '0;
    logic [2:0]  funct3 = '0;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic        rv0 = 1'b0, rv1 = 1'b0;
    logic        rr0, rsv0, af0, rr1, rsv1, af1;
    logic [31:0] rd0, rd1;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] mem0 [int];
    logic [31:0] mem1 [int];
    logic [31:0] got, e_a, e_b;
    logic        f_a, f_b;
    int          lat;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(D0), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .reqValid(rv0), .reqReady(rr0), .address(address),
        .writeData(writeData), .funct3(funct3), .memRead(memRead), .memWrite(memWrite),
        .respValid(rsv0), .readData(rd0), .accessFault(af0)
    );

    data_mem_responder #(.DEPTH_WORDS(D1), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .reqValid(rv1), .reqReady(rr1), .address(address),
        .writeData(writeData), .funct3(funct3), .memRead(memRead), .memWrite(memWrite),
        .respValid(rsv1), .readData(rd1), .accessFault(af1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic resp_of(input int sel);
        return (sel == 0) ? rsv0 : rsv1;
    endfunction
    function automatic logic ready_of(input int sel);
        return (sel == 0) ? rr0 : rr1;
    endfunction
    function automatic logic fault_of(input int sel);
        return (sel == 0) ? af0 : af1;
    endfunction
    function automatic logic [31:0] data_of(input int sel);
        return (sel == 0) ? rd0 : rd1;
    endfunction

    // Reference: little-endian word store keyed by word index modulo depth.
    task automatic model_access(input int sel, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, input logic rd, input logic wr,
                                output logic [31:0] data, output logic fault);
        int depth;
        int idx;
        int lane;
        logic [31:0] w, bv, hv;
        depth = (sel == 0) ? D0 : D1;
        idx   = int'((a / 4) % depth);
        lane  = int'(a % 4);
        if (sel == 0) w = mem0.exists(idx) ? mem0[idx] : 32'h0;
        else          w = mem1.exists(idx) ? mem1[idx] : 32'h0;
        fault = 1'b0;
        data  = 32'h0;
        if (wr)      fault = (f3 > 3'd2);
        else if (rd) fault = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if ((wr || rd) && (f3 == 3'd1 || f3 == 3'd5) && (lane % 2 == 1)) fault = 1'b1;
        if ((wr || rd) && f3 == 3'd2 && lane != 0) fault = 1'b1;
        if (!fault && wr) begin
            case (f3)
                3'd0: w = (w & ~(32'hFF << (8 * lane))) | ((wd & 32'hFF) << (8 * lane));
                3'd1: w = (w & ~(32'hFFFF << (8 * lane))) | ((wd & 32'hFFFF) << (8 * lane));
                default: w = wd;
            endcase
            if (sel == 0) mem0[idx] = w;
            else          mem1[idx] = w;
        end else if (!fault && rd) begin
            bv = (w >> (8 * lane)) & 32'hFF;
            hv = (w >> (8 * lane)) & 32'hFFFF;
            case (f3)
                3'd0: data = (bv >= 128) ? (bv | 32'hFFFFFF00) : bv;
                3'd1: data = (hv >= 32768) ? (hv | 32'hFFFF0000) : hv;
                3'd2: data = w;
                3'd4: data = bv;
                3'd5: data = hv;
                default: data = 32'h0;
            endcase
        end
    endtask

    task automatic xact(input int sel, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic rd, input logic wr,
                        output logic [31:0] obs);
        logic [31:0] ed;
        logic        ef;
        int          n;
        model_access(sel, a, wd, f3, rd, wr, ed, ef);
        @(negedge clk);
        address = a; writeData = wd; funct3 = f3; memRead = rd; memWrite = wr;
        check_eq("ready_idle", ready_of(sel), 1);
        if (sel == 0) rv0 = 1'b1;
        else          rv1 = 1'b1;
        @(posedge clk); #1;
        rv0 = 1'b0; rv1 = 1'b0;
        n = 0;
        while (!resp_of(sel) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", n, (sel == 0) ? 2 : 0);
        check_eq("read_data", data_of(sel), ed);
        check_eq("fault", fault_of(sel), ef);
        obs = data_of(sel);
        @(posedge clk); #1;
        check_eq("resp_pulse", resp_of(sel), 0);
        check_eq("data_held", data_of(sel), ed);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_ready0", rr0, 1);
        check_eq("rst_resp0", rsv0, 0);
        check_eq("rst_data0", rd0, 0);
        check_eq("rst_fault0", af0, 0);
        check_eq("rst_ready1", rr1, 1);
        check_eq("rst_resp1", rsv1, 0);
        rst_n = 1'b1;

        xact(0, 32'h100, 32'hDEADBEEF, 3'd2, 1'b0, 1'b1, got);
        xact(0, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, got); check_eq("lw_100", got, 32'hDEADBEEF);
        xact(0, 32'h103, 32'h0, 3'd0, 1'b1, 1'b0, got); check_eq("lb_103", got, 32'hFFFFFFDE);
        xact(0, 32'h103, 32'h0, 3'd4, 1'b1, 1'b0, got); check_eq("lbu_103", got, 32'h000000DE);
        xact(0, 32'h102, 32'h0, 3'd1, 1'b1, 1'b0, got); check_eq("lh_102", got, 32'hFFFFDEAD);
        xact(0, 32'h100, 32'h0, 3'd5, 1'b1, 1'b0, got); check_eq("lhu_100", got, 32'h0000BEEF);
        xact(0, 32'h101, 32'h12345655, 3'd0, 1'b0, 1'b1, got);
        xact(0, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, got); check_eq("after_sb", got, 32'hDEAD55EF);
        xact(0, 32'h102, 32'h0000CAFE, 3'd1, 1'b0, 1'b1, got);
        xact(0, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, got); check_eq("after_sh", got, 32'hCAFE55EF);
        xact(0, 32'h101, 32'h0, 3'd1, 1'b1, 1'b0, got); check_eq("lh_mis_data", got, 32'h0);
        check_eq("lh_mis_fault", af0, 1);
        xact(0, 32'h102, 32'h0, 3'd2, 1'b0, 1'b1, got); check_eq("sw_mis_fault", af0, 1);
        xact(0, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, got); check_eq("no_mis_write", got, 32'hCAFE55EF);
        xact(0, 32'h100, 32'h0, 3'd3, 1'b1, 1'b0, got); check_eq("ld_f3_011", af0, 1);
        xact(0, 32'h1100, 32'h0, 3'd2, 1'b1, 1'b0, got); check_eq("alias0", got, 32'hCAFE55EF);

        // reqValid held high: second request must wait for IDLE after RESP.
        model_access(0, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, e_a, f_a);
        model_access(0, 32'h103, 32'h0, 3'd0, 1'b1, 1'b0, e_b, f_b);
        @(negedge clk);
        address = 32'h100; funct3 = 3'd2; memRead = 1'b1; memWrite = 1'b0; rv0 = 1'b1;
        @(posedge clk); #1;
        check_eq("hold_rdy_w1", rr0, 0);
        address = 32'h103; funct3 = 3'd0;
        @(posedge clk); #1;
        check_eq("hold_rdy_w2", rr0, 0);
        check_eq("hold_resp_w2", rsv0, 0);
        @(posedge clk); #1;
        check_eq("hold_resp", rsv0, 1);
        check_eq("hold_rdy_resp", rr0, 0);
        check_eq("hold_data_a", rd0, e_a);
        @(posedge clk); #1;
        check_eq("hold_idle_rdy", rr0, 1);
        check_eq("hold_idle_resp", rsv0, 0);
        @(posedge clk); #1;
        check_eq("hold_accept_b", rr0, 0);
        rv0 = 1'b0;
        lat = 0;
        while (!rsv0 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("hold_lat_b", lat, 2);
        check_eq("hold_data_b", rd0, e_b);
        check_eq("hold_data_b_lit", rd0, 32'hFFFFFFCA);
        @(posedge clk); #1;

        // Reset during WAIT aborts a store.
        xact(0, 32'h200, 32'h11112222, 3'd2, 1'b0, 1'b1, got);
        xact(0, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, got);
        @(negedge clk);
        address = 32'h200; writeData = 32'hA5A5A5A5; funct3 = 3'd2;
        memRead = 1'b0; memWrite = 1'b1; rv0 = 1'b1;
        @(posedge clk); #1;
        rv0 = 1'b0;
        check_eq("abort_in_wait", rr0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_data", rd0, 0);
        check_eq("abort_resp", rsv0, 0);
        check_eq("abort_fault", af0, 0);
        check_eq("abort_ready", rr0, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xact(0, 32'h200, 32'h0, 3'd2, 1'b1, 1'b0, got); check_eq("abort_old", got, 32'h11112222);

        // Zero-wait instance, aliasing at 4*DEPTH.
        xact(1, 32'h140, 32'h5A5A0001, 3'd2, 1'b0, 1'b1, got);
        xact(1, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, got); check_eq("alias1", got, 32'h5A5A0001);

        for (int i = 0; i < 16; i++) begin
            xact(0, 32'h300 + 32'(4 * i), $urandom, 3'd2, 1'b0, 1'b1, got);
            xact(1, 32'(4 * i), $urandom, 3'd2, 1'b0, 1'b1, got);
        end
        for (int i = 0; i < 200; i++) begin
            int          sel;
            logic [31:0] a;
            sel = int'($urandom_range(0, 1));
            if (sel == 0) a = 32'h300 + $urandom_range(0, 63) + 32'h1000 * $urandom_range(0, 15);
            else          a = $urandom_range(0, 63) + 32'h40 * $urandom_range(0, 1000);
            xact(sel, a, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), got);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
